// File: rtl/pipe_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the WB-stage select code that picks MDU_out.
package pipe_mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  localparam logic [1:0] WB_SEL_MDU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  // MULT/MULTU/DIV/DIVU all have op[2] clear; they are the iterative ops.
  function automatic logic is_arith_op(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/pipe_mdu_iter_step.sv
// One radix-2 iteration of the multiply/divide datapath. The accumulator
// holds {upper, lower}: for multiply {partial product, multiplier}, for
// divide {remainder, dividend/quotient}.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  // Shift-add multiply step, or restoring shift-subtract divide step.
  always_comb begin
    sum       = {1'b0, acc_in[2*WIDTH-1:WIDTH]} +
                (acc_in[0] ? {1'b0, operand} : '0);
    rem_shift = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    diff      = rem_shift - {1'b0, operand};
    acc_out   = {sum, acc_in[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {rem_shift[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/pipe_mdu.sv
// Iterative multiply/divide unit holding architectural HI/LO. Operands are
// reduced to magnitudes on issue, iterated WIDTH times, then sign-corrected
// in FIX when HI/LO are written.
module pipe_mdu
  import pipe_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mdu_out
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t         state_q, state_d;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [WIDTH-1:0]   operand_q, a_raw_q;
  logic               is_div_q, neg_res_q, rem_neg_q, div_zero_q;
  logic               start_arith, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign start_arith = start && is_arith_op(op);
  assign is_signed   = ~op[0];
  assign a_neg       = is_signed & a[WIDTH-1];
  assign b_neg       = is_signed & b[WIDTH-1];
  assign mag_a       = a_neg ? -a : a;
  assign mag_b       = b_neg ? -b : b;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc_q),
    .operand (operand_q),
    .is_div  (is_div_q),
    .acc_out (acc_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: issue from IDLE, WIDTH steps in CALC, one fix-up cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_arith) state_d = CALC;
      CALC:    if (count_q == CW'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered busy/done so the hazard logic sees glitch-free flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_q == FIX);
    end
  end

  // Operand latch on issue and accumulator iteration while in CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      acc_q      <= '0;
      operand_q  <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_arith) begin
          count_q    <= '0;
          acc_q      <= {{WIDTH{1'b0}}, mag_a};
          operand_q  <= mag_b;
          a_raw_q    <= a;
          is_div_q   <= op[1];
          neg_res_q  <= a_neg ^ b_neg;
          rem_neg_q  <= a_neg;
          div_zero_q <= (b == '0);
        end
        CALC: begin
          acc_q   <= acc_step;
          count_q <= count_q + 1'b1;
        end
        default: count_q <= '0;
      endcase
    end
  end

  // Sign correction and divide-by-zero substitution applied in FIX.
  always_comb begin
    prod_fixed = neg_res_q ? -acc_q : acc_q;
    fix_hi     = prod_fixed[2*WIDTH-1:WIDTH];
    fix_lo     = prod_fixed[WIDTH-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        fix_hi = a_raw_q;
        fix_lo = '1;
      end else begin
        fix_lo = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        fix_hi = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end
    end
  end

  // HI/LO: direct moves from IDLE, arithmetic results only in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state_q == FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else if (state_q == IDLE && start) begin
      if (op == MDU_MTHI) hi <= a;
      if (op == MDU_MTLO) lo <= a;
    end
  end

  assign mdu_out = rd_hi ? hi : lo;

endmodule

// File: tb/tb_pipe_mdu.sv
// Self-checking bench for pipe_mdu against a plain-arithmetic HI/LO model.
module tb_pipe_mdu;
  import pipe_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        rd_hi = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo, mdu_out;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int LAT = 33;

  pipe_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .rd_hi(rd_hi), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  // Reference: MIPS HI/LO semantics straight from 64-bit integer arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] av,
                                input logic [31:0] bv,
                                output logic [31:0] ehi, output logic [31:0] elo);
    longint          sa = $signed(av);
    longint          sb = $signed(bv);
    longint unsigned ua = {32'h0, av};
    longint unsigned ub = {32'h0, bv};
    longint          p, q, r;
    longint unsigned up, uq, ur;
    ehi = '0; elo = '0;
    case (o)
      MDU_MULT:  begin p = sa * sb; ehi = p[63:32]; elo = p[31:0]; end
      MDU_MULTU: begin up = ua * ub; ehi = up[63:32]; elo = up[31:0]; end
      MDU_DIV: begin
        if (bv == 0) begin ehi = av; elo = 32'hFFFFFFFF; end
        else begin q = sa / sb; r = sa % sb; ehi = r[31:0]; elo = q[31:0]; end
      end
      MDU_DIVU: begin
        if (bv == 0) begin ehi = av; elo = 32'hFFFFFFFF; end
        else begin uq = ua / ub; ur = ua % ub; ehi = ur[31:0]; elo = uq[31:0]; end
      end
      default: ;
    endcase
  endfunction

  // Present one start at the current negedge; return at the next negedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Count busy cycles (bounded); leaves the bench at the negedge after busy drops.
  task automatic wait_done(output int cyc, output bit saw_done);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    saw_done = (done === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
    n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Issue one arithmetic op, check latency, done pulse, HI/LO and mdu_out.
  task automatic run_check(input string name, input logic [2:0] o,
                           input logic [31:0] av, input logic [31:0] bv);
    int cyc; bit dn; logic [31:0] ehi, elo;
    model(o, av, bv, ehi, elo);
    issue(o, av, bv);
    wait_done(cyc, dn);
    n_cmp++; if (cyc != LAT) begin n_fail++; $display("[TB] FAIL %s_latency got %0d want %0d", name, cyc, LAT); end
    n_cmp++; if (!dn) begin n_fail++; $display("[TB] FAIL %s_done got %b want 1", name, done); end
    n_cmp++; if (hi !== ehi) begin n_fail++; $display("[TB] FAIL %s_hi a=%h b=%h got %h want %h", name, av, bv, hi, ehi); end
    n_cmp++; if (lo !== elo) begin n_fail++; $display("[TB] FAIL %s_lo a=%h b=%h got %h want %h", name, av, bv, lo, elo); end
    rd_hi = 1'b0; #1;
    n_cmp++; if (mdu_out !== elo) begin n_fail++; $display("[TB] FAIL %s_out_lo got %h want %h", name, mdu_out, elo); end
    rd_hi = 1'b1; #1;
    n_cmp++; if (mdu_out !== ehi) begin n_fail++; $display("[TB] FAIL %s_out_hi got %h want %h", name, mdu_out, ehi); end
    rd_hi = 1'b0;
  endtask

  task automatic test_mult();
    run_check("mult_neg", MDU_MULT, 32'hFFFFFFFD, 32'd5);
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL done_one_cycle got %b want 0", done); end
    run_check("mult_minmin", MDU_MULT, 32'h80000000, 32'h80000000);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_check("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    // Still in the done cycle: a new issue must be accepted.
    run_check("b2b_divu", MDU_DIVU, 32'd100, 32'd7);
    @(negedge clk);
  endtask

  task automatic test_div();
    run_check("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2);
    @(negedge clk);
    run_check("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    @(negedge clk);
    run_check("div_negneg", MDU_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9);
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    run_check("divu_zero", MDU_DIVU, 32'd7, 32'd0);
    @(negedge clk);
    run_check("div_zero_neg", MDU_DIV, 32'hFFFFFFF0, 32'd0);
    @(negedge clk);
  endtask

  task automatic test_moves();
    bit rose = 0;
    logic [31:0] old_lo = lo;
    issue(MDU_MTHI, 32'h12345678, 32'h0);
    n_cmp++; if (hi !== 32'h12345678) begin n_fail++; $display("[TB] FAIL mthi got %h want 12345678", hi); end
    n_cmp++; if (lo !== old_lo) begin n_fail++; $display("[TB] FAIL mthi_lo_kept got %h want %h", lo, old_lo); end
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0) rose = 1;
      @(negedge clk);
    end
    n_cmp++; if (rose) begin n_fail++; $display("[TB] FAIL mthi_busy got 1 want 0"); end
    issue(MDU_MTLO, 32'hCAFEF00D, 32'h0);
    n_cmp++; if (lo !== 32'hCAFEF00D || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mtlo got %h busy %b want cafef00d busy 0", lo, busy); end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int cyc; bit dn; logic [31:0] ehi, elo;
    model(MDU_MULT, 32'd1234, 32'hFFFFFF00, ehi, elo);
    issue(MDU_MULT, 32'd1234, 32'hFFFFFF00);
    repeat (4) @(negedge clk);
    start = 1'b1; op = MDU_MTLO; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, dn);
    n_cmp++; if (cyc != LAT - 5) begin n_fail++; $display("[TB] FAIL ignored_latency got %0d want %0d", cyc, LAT - 5); end
    n_cmp++; if (lo !== elo || hi !== ehi || !dn) begin n_fail++; $display("[TB] FAIL ignored_result got %h_%h done %b want %h_%h done 1", hi, lo, dn, ehi, elo); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] av, bv;
    for (int i = 0; i < 24; i++) begin
      o  = 3'($urandom_range(0, 3));
      av = $urandom;
      bv = $urandom;
      if ($urandom_range(0, 5) == 0) bv = 32'h0;
      else if ($urandom_range(0, 3) == 0) bv = 32'($urandom_range(1, 20));
      run_check("random", o, av, bv);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    bit saw = 0;
    issue(MDU_DIV, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_busy got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_mid_hilo got %h/%h want 0/0", hi, lo); end
    for (int i = 0; i < 45; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw = 1;
      @(negedge clk);
    end
    n_cmp++; if (saw) begin n_fail++; $display("[TB] FAIL rst_mid_done got pulse want none"); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_moves();
    test_ignored_start();
    test_random();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
